// File: rtl/win_spill_fill.sv
// rtl/win_spill_fill.sv - register window spill/fill engine between the register file and the save stack
// Spills the outgoing window to a memory stack on overflow and restores it in LIFO order on underflow.
module win_spill_fill #(
   parameter int                WORD_W     = 16,
   parameter int                ADDR_W     = 16,
   parameter int                WIN_REGS   = 4,
   parameter logic [2:0]        SEL_BASE   = 3'd4,
   parameter logic [ADDR_W-1:0] STACK_BASE = 16'hF000,
   parameter int                DEPTH_W    = 8
) (
   input  logic               clock,
   input  logic               reset_L,
   input  logic               ovf_req,
   input  logic               unf_req,
   output logic [2:0]         rf_sel,
   input  logic [WORD_W-1:0]  rf_rdata,
   output logic [WORD_W-1:0]  rf_wdata,
   output logic               rf_load_L,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [WORD_W-1:0]  mem_wdata,
   input  logic [WORD_W-1:0]  mem_rdata,
   output logic               mem_re_L,
   output logic               mem_we_L,
   input  logic               mem_ready,
   output logic               stall_L,
   output logic               done,
   output logic               err,
   output logic [DEPTH_W-1:0] depth
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SPILL,
      S_FILL_RD,
      S_FILL_WR,
      S_DONE
   } state_t;

   localparam logic [2:0]         LAST_I = 3'(WIN_REGS - 1);
   localparam logic [ADDR_W-1:0]  A_ONE  = 1;
   localparam logic [DEPTH_W-1:0] D_ONE  = 1;

   state_t            state;
   logic [ADDR_W-1:0] sp;
   logic [2:0]        i;

   // Spill data is taken straight from the register file read port so it tracks rf_sel.
   assign mem_wdata = (state == S_SPILL) ? rf_rdata : '0;

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         state     <= S_IDLE;
         sp        <= STACK_BASE;
         i         <= 3'd0;
         depth     <= '0;
         rf_sel    <= SEL_BASE;
         rf_wdata  <= '0;
         rf_load_L <= 1'b1;
         mem_addr  <= STACK_BASE;
         mem_re_L  <= 1'b1;
         mem_we_L  <= 1'b1;
         stall_L   <= 1'b1;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done      <= 1'b0;
         err       <= 1'b0;
         rf_load_L <= 1'b1;
         case (state)
            S_IDLE: begin
               if (ovf_req && unf_req) begin
                  err <= 1'b1;
               end else if (ovf_req && (&depth)) begin
                  err <= 1'b1;
               end else if (ovf_req) begin
                  state    <= S_SPILL;
                  i        <= 3'd0;
                  rf_sel   <= SEL_BASE;
                  mem_addr <= sp;
                  mem_we_L <= 1'b0;
                  stall_L  <= 1'b0;
               end else if (unf_req && (depth == '0)) begin
                  err <= 1'b1;
               end else if (unf_req) begin
                  state    <= S_FILL_RD;
                  i        <= LAST_I;
                  mem_addr <= sp - A_ONE;
                  mem_re_L <= 1'b0;
                  stall_L  <= 1'b0;
               end
            end
            S_SPILL: begin
               if (mem_ready) begin
                  sp       <= sp + A_ONE;
                  i        <= i + 3'd1;
                  mem_addr <= sp + A_ONE;
                  if (i == LAST_I) begin
                     mem_we_L <= 1'b1;
                     depth    <= depth + D_ONE;
                     done     <= 1'b1;
                     state    <= S_DONE;
                  end else begin
                     rf_sel <= SEL_BASE + i + 3'd1;
                  end
               end
            end
            S_FILL_RD: begin
               if (mem_ready) begin
                  rf_wdata  <= mem_rdata;
                  sp        <= sp - A_ONE;
                  mem_re_L  <= 1'b1;
                  rf_sel    <= SEL_BASE + i;
                  rf_load_L <= 1'b0;
                  state     <= S_FILL_WR;
               end
            end
            S_FILL_WR: begin
               if (i == 3'd0) begin
                  depth <= depth - D_ONE;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  i        <= i - 3'd1;
                  mem_addr <= sp - A_ONE;
                  mem_re_L <= 1'b0;
                  state    <= S_FILL_RD;
               end
            end
            S_DONE: begin
               stall_L <= 1'b1;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_win_spill_fill.sv
// tb/tb_win_spill_fill.sv - directed bench for win_spill_fill with a transaction-level stack model
module tb_win_spill_fill;

   logic        clock = 1'b0;
   logic        reset_L;
   logic        ovf_req, unf_req;
   logic [2:0]  rf_sel;
   logic [15:0] rf_rdata, rf_wdata;
   logic        rf_load_L;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_re_L, mem_we_L, mem_ready;
   logic        stall_L, done, err;
   logic [7:0]  depth;

   win_spill_fill dut (
      .clock(clock), .reset_L(reset_L), .ovf_req(ovf_req), .unf_req(unf_req),
      .rf_sel(rf_sel), .rf_rdata(rf_rdata), .rf_wdata(rf_wdata), .rf_load_L(rf_load_L),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_re_L(mem_re_L), .mem_we_L(mem_we_L), .mem_ready(mem_ready),
      .stall_L(stall_L), .done(done), .err(err), .depth(depth)
   );

   always #5 clock = ~clock;

   logic [15:0] mem_arr [0:65535];
   logic [15:0] rf_arr  [0:7];

   assign rf_rdata  = rf_arr[rf_sel];
   assign mem_rdata = mem_arr[mem_addr];

   always @(posedge clock) begin
      if (reset_L && !mem_we_L && mem_ready) mem_arr[mem_addr] = mem_wdata;
      if (reset_L && !rf_load_L) rf_arr[rf_sel] = rf_wdata;
   end

   int n_cmp = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: strobe active with no transaction expected", name);
   endtask

   typedef struct {
      logic [15:0] a;
      logic [15:0] d;
   } xact_t;

   // Model: a LIFO of saved words plus queues of the transactions each request must produce.
   bit          m_busy, m_live, m_spill, m_done, m_err;
   int          m_depth;
   int          m_busy_cycles;
   logic [15:0] m_sp = 16'hF000;
   logic [15:0] m_stack [$];
   xact_t       m_wq [$];
   logic [15:0] m_rq [$];
   xact_t       m_lq [$];

   always @(negedge clock) begin
      bit nd, ne;
      if (!reset_L) begin
         m_busy = 0; m_live = 0; m_done = 0; m_err = 0; m_depth = 0;
         m_sp = 16'hF000; m_busy_cycles = 0;
         m_stack.delete(); m_wq.delete(); m_rq.delete(); m_lq.delete();
      end else begin
         check("stall_L", 32'(stall_L), 32'(!m_busy));
         check("done", 32'(done), 32'(m_done));
         check("err", 32'(err), 32'(m_err));
         check("depth", 32'(depth), 32'(m_depth));
         check("strobe_excl", 32'(!mem_we_L && !mem_re_L), 32'(0));
         if (!mem_we_L) begin
            if (m_wq.size() == 0) fail_now("mem_write");
            else begin
               check("wr_addr", 32'(mem_addr), 32'(m_wq[0].a));
               check("wr_data", 32'(mem_wdata), 32'(m_wq[0].d));
               if (mem_ready) void'(m_wq.pop_front());
            end
         end
         if (!mem_re_L) begin
            if (m_rq.size() == 0) fail_now("mem_read");
            else begin
               check("rd_addr", 32'(mem_addr), 32'(m_rq[0]));
               if (mem_ready) void'(m_rq.pop_front());
            end
         end
         if (!rf_load_L) begin
            if (m_lq.size() == 0 || m_rq.size() + 1 > m_lq.size()) fail_now("rf_load");
            else begin
               check("rf_sel", 32'(rf_sel), 32'(m_lq[0].a));
               check("rf_wdata", 32'(rf_wdata), 32'(m_lq[0].d));
               void'(m_lq.pop_front());
            end
         end
         nd = 0; ne = 0;
         if (m_done) begin
            m_busy = 0;
         end else if (m_live) begin
            if (m_wq.size() == 0 && m_rq.size() == 0 && m_lq.size() == 0) begin
               nd = 1; m_live = 0;
               m_depth = m_spill ? m_depth + 1 : m_depth - 1;
            end
         end else if (!m_busy) begin
            if (ovf_req && unf_req) ne = 1;
            else if (ovf_req && m_depth == 255) ne = 1;
            else if (ovf_req) begin
               m_busy = 1; m_live = 1; m_spill = 1;
               for (int k = 0; k < 4; k++) begin
                  m_stack.push_back(rf_arr[4+k]);
                  m_wq.push_back('{m_sp + 16'(k), rf_arr[4+k]});
               end
               m_sp = m_sp + 16'd4;
            end else if (unf_req && m_depth == 0) ne = 1;
            else if (unf_req) begin
               m_busy = 1; m_live = 1; m_spill = 0;
               for (int k = 0; k < 4; k++) begin
                  m_rq.push_back(m_sp - 16'(k + 1));
                  m_lq.push_back('{16'(7 - k), m_stack.pop_back()});
               end
               m_sp = m_sp - 16'd4;
            end
         end
         m_done = nd;
         m_err  = ne;
         m_busy_cycles = m_busy ? m_busy_cycles + 1 : 0;
         if (m_busy_cycles > 100) begin
            n_cmp++; n_fail++;
            $display("FAIL watchdog: busy %0d cycles, expected completion", m_busy_cycles);
            m_busy = 0; m_live = 0; m_busy_cycles = 0;
            m_wq.delete(); m_rq.delete(); m_lq.delete();
         end
      end
   end

   task automatic pulse(input bit o, input bit u);
      @(posedge clock); #1 ovf_req = o; unf_req = u;
      @(posedge clock); #1 ovf_req = 0; unf_req = 0;
   endtask

   task automatic wait_idle(output int stall_cnt, output bit err_seen, output bit done_seen);
      stall_cnt = 0; err_seen = 0; done_seen = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clock);
         if (err) err_seen = 1;
         if (done) done_seen = 1;
         if (stall_L) break;
         stall_cnt++;
      end
   endtask

   task automatic run_op(input bit o, input bit u, output int stall_cnt, output bit err_seen,
                         output bit done_seen);
      pulse(o, u);
      wait_idle(stall_cnt, err_seen, done_seen);
   endtask

   task automatic set_win(input logic [15:0] a, b, c, d);
      rf_arr[4] = a; rf_arr[5] = b; rf_arr[6] = c; rf_arr[7] = d;
   endtask

   int sc, nl;
   bit es, ds;

   initial begin
      reset_L = 0; ovf_req = 0; unf_req = 0; mem_ready = 1;
      for (int k = 0; k < 8; k++) rf_arr[k] = 16'h0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_stall_L", 32'(stall_L), 32'(1));
      check("rst_strobes", 32'({rf_load_L, mem_re_L, mem_we_L}), 32'(3'b111));
      check("rst_done_err", 32'({done, err}), 32'(0));
      check("rst_rf_sel", 32'(rf_sel), 32'(4));
      check("rst_mem_addr", 32'(mem_addr), 32'(16'hF000));
      check("rst_data", 32'({rf_wdata, mem_wdata}), 32'(0));
      check("rst_depth", 32'(depth), 32'(0));
      reset_L = 1;

      set_win(16'h1111, 16'h2222, 16'h3333, 16'h4444);
      run_op(1, 0, sc, es, ds);
      check("t1_stall_cycles", 32'(sc), 32'(5));
      check("t1_done", 32'(ds), 32'(1));
      check("t1_depth", 32'(depth), 32'(1));
      check("t1_mem_f000", 32'(mem_arr[16'hF000]), 32'(16'h1111));
      check("t1_mem_f003", 32'(mem_arr[16'hF003]), 32'(16'h4444));

      set_win(16'h0, 16'h0, 16'h0, 16'h0);
      run_op(0, 1, sc, es, ds);
      check("t2_stall_cycles", 32'(sc), 32'(9));
      check("t2_rf7", 32'(rf_arr[7]), 32'(16'h4444));
      check("t2_rf6", 32'(rf_arr[6]), 32'(16'h3333));
      check("t2_rf5", 32'(rf_arr[5]), 32'(16'h2222));
      check("t2_rf4", 32'(rf_arr[4]), 32'(16'h1111));
      check("t2_depth", 32'(depth), 32'(0));

      run_op(0, 1, sc, es, ds);
      check("t3_err", 32'(es), 32'(1));
      check("t3_stall_cycles", 32'(sc), 32'(0));

      set_win(16'hA0A0, 16'hB0B0, 16'hC0C0, 16'hD0D0);
      @(posedge clock); #1 ovf_req = 1;
      @(posedge clock); #1 ovf_req = 0;
      @(posedge clock); #1 mem_ready = 0;
      repeat (3) begin
         @(negedge clock);
         check("t4_wait_addr", 32'(mem_addr), 32'(16'hF001));
         check("t4_wait_data", 32'(mem_wdata), 32'(16'hB0B0));
      end
      @(posedge clock); #1 mem_ready = 1;
      wait_idle(sc, es, ds);
      check("t4_mem_f001", 32'(mem_arr[16'hF001]), 32'(16'hB0B0));
      check("t4_mem_f002", 32'(mem_arr[16'hF002]), 32'(16'hC0C0));
      check("t4_depth", 32'(depth), 32'(1));

      run_op(1, 1, sc, es, ds);
      check("t5_both_err", 32'(es), 32'(1));
      check("t5_both_depth", 32'(depth), 32'(1));
      set_win(16'h0101, 16'h0202, 16'h0303, 16'h0404);
      pulse(1, 0);
      repeat (2) @(posedge clock);
      #1 ovf_req = 1;
      @(posedge clock); #1 ovf_req = 0;
      wait_idle(sc, es, ds);
      check("t5_depth", 32'(depth), 32'(2));
      check("t5_mem_f007", 32'(mem_arr[16'hF007]), 32'(16'h0404));

      pulse(0, 1);
      nl = 0;
      for (int c = 0; c < 50 && nl < 2; c++) begin
         @(negedge clock);
         if (!rf_load_L) nl++;
      end
      check("t6_loads_seen", 32'(nl), 32'(2));
      @(posedge clock); #2 reset_L = 0;
      #1;
      check("t6_stall_L", 32'(stall_L), 32'(1));
      check("t6_strobes", 32'({rf_load_L, mem_re_L, mem_we_L}), 32'(3'b111));
      check("t6_depth", 32'(depth), 32'(0));
      check("t6_mem_addr", 32'(mem_addr), 32'(16'hF000));
      check("t6_rf6", 32'(rf_arr[6]), 32'(16'h0303));
      repeat (2) @(posedge clock);
      #1 reset_L = 1;
      run_op(1, 0, sc, es, ds);
      check("t6_sp_reset", 32'(mem_arr[16'hF000]), 32'(16'h0101));
      check("t6_stall_cycles", 32'(sc), 32'(5));

      for (int n = 0; n < 254; n++) run_op(1, 0, sc, es, ds);
      check("t7_full_depth", 32'(depth), 32'(255));
      run_op(1, 0, sc, es, ds);
      check("t7_full_err", 32'(es), 32'(1));
      check("t7_full_stall", 32'(sc), 32'(0));
      run_op(0, 1, sc, es, ds);
      check("t7_fill_depth", 32'(depth), 32'(254));
      check("t7_fill_stall", 32'(sc), 32'(9));

      repeat (2) @(posedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
